// File: rtl/traffic_ctrl_fsm.sv
// Intersection light sequencer: six-state FSM with a LOAD1/LOAD2/RUN phase per state and a seconds down-counter.
// Optional pedestrian walk feature is compiled in with `define TRAFFIC_WALK_EN.
module traffic_ctrl_fsm #(
    parameter int MIN_TIME = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       sensor,
    input  logic [3:0] time_val,
`ifdef TRAFFIC_WALK_EN
    input  logic       walk_req,
    output logic       walk,
`endif
    output logic [1:0] intervel,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        MG1 = 3'd0, MG2 = 3'd1, MY = 3'd2, SG = 3'd3, SGX = 3'd4, SY = 3'd5
    } state_t;
    typedef enum logic [1:0] {LOAD1 = 2'd0, LOAD2 = 2'd1, RUN = 2'd2} phase_t;

    localparam logic [3:0] MIN_T = 4'(MIN_TIME);
    localparam logic [2:0] L_RED = 3'b100, L_YEL = 3'b010, L_GRN = 3'b001;

    state_t     r_state, w_nstate, w_succ;
    phase_t     r_phase, w_nphase;
    logic [3:0] r_timer, w_ntimer;
    logic       w_enter;
    logic [1:0] r_intervel, w_nint;
    logic [2:0] r_main, r_side, w_nmain, w_nside;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= MG1;
            r_phase    <= LOAD1;
            r_timer    <= 4'd0;
            r_intervel <= 2'b00;
            r_main     <= L_GRN;
            r_side     <= L_RED;
        end else begin
            r_state <= w_nstate;
            r_phase <= w_nphase;
            r_timer <= w_ntimer;
            if (w_enter) begin
                r_intervel <= w_nint;
                r_main     <= w_nmain;
                r_side     <= w_nside;
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_nphase = r_phase;
        w_ntimer = r_timer;
        w_enter  = 1'b0;
        w_succ   = MG1;
        case (r_state)
            MG1:     w_succ = MG2;
            MG2:     w_succ = MY;
            MY:      w_succ = SG;
            SG:      w_succ = sensor ? SGX : SY;
            SGX:     w_succ = SY;
            default: w_succ = MG1;
        endcase
        case (r_phase)
            LOAD1: w_nphase = LOAD2;
            LOAD2: begin
                w_nphase = RUN;
                w_ntimer = (time_val < MIN_T) ? MIN_T : time_val;
            end
            RUN: if (sec_tick) begin
                // <=1 rather than ==1 so a zero timer (MIN_TIME=0) still expires
                if (r_timer <= 4'd1) begin
                    w_enter  = 1'b1;
                    w_nstate = w_succ;
                    w_nphase = LOAD1;
                    w_ntimer = 4'd0;
                end else begin
                    w_ntimer = r_timer - 4'd1;
                end
            end
            default: w_nphase = LOAD1;
        endcase
        if (r_state > SY) begin
            w_enter  = 1'b1;
            w_nstate = MG1;
            w_nphase = LOAD1;
            w_ntimer = 4'd0;
        end
    end

    // Output image of the state being entered; MG2 picks its duration from sensor on this edge.
    always_comb begin
        w_nint  = 2'b00;
        w_nmain = L_RED;
        w_nside = L_RED;
        case (w_nstate)
            MG2: begin w_nmain = L_GRN; w_nint = sensor ? 2'b01 : 2'b00; end
            MY:  begin w_nmain = L_YEL; w_nint = 2'b10; end
            SG:  begin w_nside = L_GRN; end
            SGX: begin w_nside = L_GRN; w_nint = 2'b01; end
            SY:  begin w_nside = L_YEL; w_nint = 2'b10; end
            default: w_nmain = L_GRN;
        endcase
    end

    assign intervel   = r_intervel;
    assign main_light = r_main;
    assign side_light = r_side;
    assign state_dbg  = r_state;

`ifdef TRAFFIC_WALK_EN
    logic r_walk_pend, r_walk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_walk_pend <= 1'b0;
            r_walk      <= 1'b0;
        end else if (w_enter && w_nstate == SG) begin
            r_walk      <= r_walk_pend;
            r_walk_pend <= walk_req;
        end else begin
            if (walk_req) r_walk_pend <= 1'b1;
            if (w_enter)  r_walk      <= (w_nstate == SGX) ? r_walk : 1'b0;
        end
    end

    assign walk = r_walk;
`endif
endmodule

// File: doc/traffic_ctrl_fsm.md
# traffic_ctrl_fsm

Light-sequencing controller for the intersection: a state machine plus a seconds down-counter. It sits directly downstream of the time-parameter store. It selects which stored duration it needs via `intervel`, loads the returned `time_val` into its timer, and drives the main-road and side-road lamp heads. The side-street car `sensor` extends green phases.

## Interface
Parameters:
- `MIN_TIME`, default 1: floor applied to any loaded duration, in seconds.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `sec_tick`, input, 1: single-cycle pulse, once per second.
- `sensor`, input, 1: side-street vehicle present; level, already synchronised.
- `time_val`, input, 4: duration returned by the parameter store; lags `intervel` by one clock.
- `intervel`, output, 2: duration select; 00 = base, 01 = extension, 10 = yellow. 11 is never driven.
- `main_light`, output, 3: {red, yellow, green}, one-hot.
- `side_light`, output, 3: {red, yellow, green}, one-hot.
- `state_dbg`, output, 3: current state encoding, for bench observation.

## Operation
- States and encodings:
  - MG1 (0): main green. Duration base. Always goes to MG2.
  - MG2 (1): main green. Duration extension if `sensor` is high at entry, else base. Goes to MY.
  - MY (2): main yellow. Duration yellow. Goes to SG.
  - SG (3): side green. Duration base. At expiry goes to SGX if `sensor`=1, else SY.
  - SGX (4): side green. Duration extension. Goes to SY.
  - SY (5): side yellow. Duration yellow. Goes to MG1.
- Lamp outputs:
  - Main is green in MG1 and MG2, yellow in MY, red otherwise.
  - Side is green in SG and SGX, yellow in SY, red otherwise.
  - Main and side are never green or yellow at the same time.
- Each state runs in three phases: LOAD1, LOAD2, RUN.
  - LOAD1: `intervel` is already valid (registered on the state-entry edge). The parameter store registers its output on this edge.
  - LOAD2: timer <= max(`time_val`, `MIN_TIME`).
  - RUN: on each `sec_tick`, timer decrements. A tick sampled while timer==1 sets next state and LOAD1 on that edge.
- `sec_tick` is ignored during LOAD1 and LOAD2; no tick is queued.
- The timer is 4 bits wide and never wraps below 0.
- Any encoding 6–7 recovers to MG1/LOAD1 on the next edge.

## Timing
- Reset values:
  - state MG1, phase LOAD1, timer 0.
  - `intervel`=00, `main_light`=001, `side_light`=100, `state_dbg`=000.
- All outputs are registered and change only on the state-entry edge. There are no combinational paths from inputs to outputs.
- State dwell = 2 clocks + N ticks, where N = max(loaded value, `MIN_TIME`).
- The `sensor` decision for MG2 is sampled on the entry edge. For SG it is sampled on the expiry edge.
- Reset asserted mid-state forces the reset values asynchronously. After release, the first edge is treated as LOAD1 of MG1.

## Configuration
- `TRAFFIC_WALK_EN` defined:
  - Adds input `walk_req` (1-bit) and output `walk` (1-bit).
  - A `walk_req` pulse sets a pending flag in any state.
  - On entering SG with the flag set, `walk`=1 for all of SG and SGX; the flag clears on SG entry.
  - `walk`=0 in all other states and at reset.
- `TRAFFIC_WALK_EN` undefined: ports and logic are absent, and sequencing is identical.

## Test plan
- Sensor low, `time_val` model 6/3/2, `sec_tick` every 10 clocks:
  - MG1 6 s → MG2 6 s → MY 2 s → SG 6 s → SY 2 s → MG1.
  - Lamp codes match at every edge.
- Sensor held high:
  - MG2 lasts 3 s with `intervel`=01.
  - SG expiry goes to SGX, which lasts 3 s.
  - Only afterwards does SY occur.
- `time_val`=0 for the yellow select: MY and SY each last exactly 1 tick.
- `sec_tick` asserted during LOAD1 and LOAD2: the ticks are ignored and dwell is unchanged.
- Reset asserted mid-SG, between clock edges:
  - Outputs go to 001/100 and `intervel`=00 before the next edge.
  - Sequencing restarts with MG1.
- With `TRAFFIC_WALK_EN`: a `walk_req` pulse during MG1 gives `walk`=1 through SG (and SGX), then 0 in SY.
